// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter with a registered one-hot grant held until acked.
// Define RR_ARB_GNT_IDX_EN to add o_gnt_idx, the binary index of o_gnt via enc.

`ifdef RR_ARB_GNT_IDX_EN
module enc #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_onehot,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int IW = $clog2(N);

    always_comb begin
        o_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (i_onehot[k]) o_idx = o_idx | IW'(k);
        end
    end
endmodule
`endif

module rr_arb #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic [N-1:0]         i_req,
    input  logic                 i_ack,
    output logic [N-1:0]         o_gnt,
    output logic                 o_gnt_vld
`ifdef RR_ARB_GNT_IDX_EN
    ,
    output logic [$clog2(N)-1:0] o_gnt_idx
`endif
);
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, GNT} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] ptr_inc;

    // First set bit at or above start, else first set bit below it (wrap).
    function automatic logic [N-1:0] pick(input logic [N-1:0] req, input logic [IW-1:0] start);
        logic [N-1:0] win;
        logic         found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[k] && (IW'(k) >= start)) begin
                win[k] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                win[k] = 1'b1;
                found  = 1'b1;
            end
        end
        return win;
    endfunction

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_q[k]) gnt_idx = gnt_idx | IW'(k);
        end
        ptr_inc = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Re-arbitration on ack uses the advanced pointer so grants run back-to-back.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    gnt_d   = pick(i_req, ptr_q);
                    state_d = GNT;
                end
            end
            GNT: begin
                if (i_ack) begin
                    ptr_d   = ptr_inc;
                    gnt_d   = pick(i_req, ptr_inc);
                    state_d = (|i_req) ? GNT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_gnt     = gnt_q;
        o_gnt_vld = (state_q == GNT);
    end

`ifdef RR_ARB_GNT_IDX_EN
    enc #(.N(N)) u_enc (
        .i_onehot (gnt_q),
        .o_idx    (o_gnt_idx)
    );
`endif

endmodule

// File: tb/tb_rr_arb.sv
// Scoreboard bench for rr_arb: a queue-based reference model predicts each
// registered grant; a monitor pops and compares one cycle after each drive.
module tb_rr_arb;
    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          arst_n;
    logic [N-1:0]  i_req;
    logic          i_ack;
    logic [N-1:0]  o_gnt;
    logic          o_gnt_vld;
`ifdef RR_ARB_GNT_IDX_EN
    logic [IW-1:0] o_gnt_idx;
`endif

    always #5 clk = ~clk;

    rr_arb #(.N(N)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .i_req     (i_req),
        .i_ack     (i_ack),
        .o_gnt     (o_gnt),
        .o_gnt_vld (o_gnt_vld)
`ifdef RR_ARB_GNT_IDX_EN
        ,
        .o_gnt_idx (o_gnt_idx)
`endif
    );

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic          vld;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: priority start, whether a grant is outstanding, and its index.
    int   m_ptr  = 0;
    bit   m_busy = 1'b0;
    int   m_idx  = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int m_pick(input logic [N-1:0] req, input int from);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (from + k) % N;
            if (req[c[IW-1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] r, input logic a);
        exp_t e;
        int   w;
        @(negedge clk);
        i_req = r;
        i_ack = a;
        if (!m_busy) begin
            w = m_pick(r, m_ptr);
        end else if (a) begin
            m_ptr = (m_idx + 1) % N;
            w     = m_pick(r, m_ptr);
        end else begin
            w = m_idx;
        end
        m_busy = (w >= 0);
        m_idx  = m_busy ? w : 0;
        e.vld  = m_busy;
        e.gnt  = m_busy ? (N'(1) << w) : '0;
        e.idx  = m_busy ? IW'(w) : '0;
        exp_q.push_back(e);
    endtask

    task automatic model_reset;
        m_ptr  = 0;
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    // Asserts reset mid-cycle with every request pending; outputs must clear at once.
    task automatic reset_test;
        @(posedge clk);
        #3;
        i_req  = '1;
        i_ack  = 1'b0;
        arst_n = 1'b0;
        #1;
        chk("rst_now_gnt", int'(o_gnt), 0);
        chk("rst_now_vld", int'(o_gnt_vld), 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_gnt", int'(o_gnt), 0);
            chk("rst_hold_vld", int'(o_gnt_vld), 0);
`ifdef RR_ARB_GNT_IDX_EN
            chk("rst_hold_idx", int'(o_gnt_idx), 0);
`endif
        end
        i_req  = '0;
        arst_n = 1'b1;
        model_reset();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (arst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt", int'(o_gnt), int'(e.gnt));
            chk("vld", int'(o_gnt_vld), int'(e.vld));
`ifdef RR_ARB_GNT_IDX_EN
            chk("idx", int'(o_gnt_idx), int'(e.idx));
`endif
        end
    end

    initial begin
        logic [N-1:0] r;
        arst_n = 1'b0;
        i_req  = '0;
        i_ack  = 1'b0;
        repeat (2) @(negedge clk);
        chk("init_gnt", int'(o_gnt), 0);
        chk("init_vld", int'(o_gnt_vld), 0);
        arst_n = 1'b1;
        model_reset();

        // Single request, held without ack, then acked with nothing pending.
        repeat (6) step(4'b0100, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);

        // Reset while a grant is outstanding.
        step(4'b1111, 1'b0);
        reset_test();

        // Full contention, then pointer wrap with 1001.
        step(4'b1111, 1'b0);
        repeat (7) step(4'b1111, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b1001, 1'b1);

        // Sticky grant on requestor 1 while requests change.
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        repeat (3) step(4'b1101, 1'b0);
        step(4'b1101, 1'b1);
        step(4'b0000, 1'b1);

        // Ack while idle must be ignored.
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        repeat (400) begin
            r = N'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            step(r, 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #2;
        chk("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
